// File: rtl/mem_req_issue_pkg.sv
// Shared types and widths for the memory request issue block.
// Covers the request layout, the transaction ID layout and the FSM states.
package mem_req_issue_pkg;
   localparam int RW_W      = 1;
   localparam int ADDR_W    = 31;
   localparam int DATA_W    = 32;
   localparam int REQ_W     = RW_W + ADDR_W + DATA_W;
   localparam int SLOT_W    = 3;
   localparam int GEN_W     = 7;
   localparam int ID_W      = GEN_W + SLOT_W;
   localparam int NUM_SLOTS = 1 << SLOT_W;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   function automatic logic [ID_W-1:0] make_id(input logic [GEN_W-1:0] g,
                                               input logic [SLOT_W-1:0] s);
      return {g, s};
   endfunction
endpackage

// File: rtl/mem_req_issue_if.sv
// Core request, downstream issue and completion signals of mem_req_issue.
// slave is the issue block's view; master is the core/downstream side.
interface mem_req_issue_if;
   import mem_req_issue_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              access_en;
   logic [REQ_W-1:0]  request_out;
   logic [ID_W-1:0]   identification_out;
   logic              if_ready;
   logic              cpl_valid;
   logic [ID_W-1:0]   cpl_id;

   modport master (
      output req_valid, req_rw, req_addr, req_wdata, if_ready, cpl_valid, cpl_id,
      input  req_ready, access_en, request_out, identification_out
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_wdata, if_ready, cpl_valid, cpl_id,
      output req_ready, access_en, request_out, identification_out
   );
endinterface

// File: rtl/mem_req_fifo.sv
// Registered request FIFO with no pass-through: a pushed entry is visible
// at the head only after the push edge. Caller guarantees no push when full, no pop when empty.
module mem_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/mem_req_issue.sv
// Queues core memory requests, tags each with a {gen, slot} ID on issue to the
// downstream stage, retires them on matching completions, and supports draining.
module mem_req_issue
   import mem_req_issue_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int SLOTS      = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_req_issue_if.slave       bus,
   input  logic                 drain_req,
   output logic                 drain_done,
   output logic [3:0]           outstanding,
   output logic                 err_spurious
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t             state;
   req_t               wr_req, head;
   logic               push, pop, empty, full, alive;
   logic [CW-1:0]      count;
   logic [SLOTS-1:0]   busy, set_mask, clr_mask;
   logic [GEN_W-1:0]   gen [SLOTS];
   logic [SLOT_W-1:0]  free_slot, cpl_slot;
   logic [GEN_W-1:0]   cpl_gen;
   logic               any_free, issue, cpl_hit, cpl_bad;
   logic               access_q;
   logic [REQ_W-1:0]   req_q;
   logic [ID_W-1:0]    id_q;

   assign wr_req = '{rw: bus.req_rw, addr: bus.req_addr, wdata: bus.req_wdata};

   // alive holds req_ready low through reset and for the first edge after it.
   assign bus.req_ready          = alive && !full && (state == RUN);
   assign bus.access_en          = access_q;
   assign bus.request_out        = req_q;
   assign bus.identification_out = id_q;

   assign push = bus.req_valid && bus.req_ready;
   assign pop  = issue;

   mem_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REQ_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (wr_req),
      .dout  (head),
      .empty (empty),
      .full  (full),
      .count (count)
   );

   // Lowest-index free slot from the pre-edge busy vector.
   always_comb begin
      any_free  = 1'b0;
      free_slot = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            any_free  = 1'b1;
            free_slot = SLOT_W'(i);
         end
      end
   end

   assign issue    = !empty && bus.if_ready && any_free;
   assign cpl_slot = bus.cpl_id[SLOT_W-1:0];
   assign cpl_gen  = bus.cpl_id[ID_W-1:SLOT_W];
   assign cpl_hit  = bus.cpl_valid && busy[cpl_slot] && (gen[cpl_slot] == cpl_gen);
   assign cpl_bad  = bus.cpl_valid && !cpl_hit;
   assign set_mask = SLOTS'(issue) << free_slot;
   assign clr_mask = SLOTS'(cpl_hit) << cpl_slot;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alive        <= 1'b0;
         busy         <= '0;
         access_q     <= 1'b0;
         req_q        <= '0;
         id_q         <= '0;
         outstanding  <= '0;
         err_spurious <= 1'b0;
         for (int i = 0; i < SLOTS; i++) gen[i] <= '0;
      end else begin
         alive       <= 1'b1;
         busy        <= (busy | set_mask) & ~clr_mask;
         access_q    <= issue;
         outstanding <= outstanding + 4'(issue) - 4'(cpl_hit);
         if (issue) begin
            req_q <= head;
            id_q  <= make_id(gen[free_slot], free_slot);
         end
         if (cpl_bad) err_spurious <= 1'b1;
         for (int i = 0; i < SLOTS; i++)
            if (clr_mask[i]) gen[i] <= gen[i] + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         drain_done <= 1'b0;
      end else begin
         drain_done <= 1'b0;
         case (state)
            RUN:     if (drain_req) state <= DRAIN;
            DRAIN:   if (empty && outstanding == '0) begin
                        state      <= DONE;
                        drain_done <= 1'b1;
                     end
            DONE:    if (!drain_req) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_req_issue.sv
// Randomized and directed bench for mem_req_issue against a queue/array reference model.
module tb_mem_req_issue;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       drain_req = 1'b0;
   logic       drain_done, err_spurious;
   logic [3:0] outstanding;
   int         nvec = 0;
   int         nerr = 0;

   mem_req_issue_if bus();

   mem_req_issue #(.FIFO_DEPTH(DEPTH), .SLOTS(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .drain_req    (drain_req),
      .drain_done   (drain_done),
      .outstanding  (outstanding),
      .err_spurious (err_spurious)
   );

   always #5 clk = ~clk;

   // Reference model: request queue, per-slot busy/generation, drain mode 0=run 1=drain 2=done.
   logic [63:0] fq[$];
   bit          mbusy [8];
   int          mgen  [8];
   int          mst;
   bit          mready, macc, mdone, merr;
   logic [63:0] mreq;
   logic [9:0]  mid;

   function automatic int m_out();
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(mbusy[i]);
      return n;
   endfunction

   task automatic m_reset();
      fq.delete();
      for (int i = 0; i < 8; i++) begin mbusy[i] = 0; mgen[i] = 0; end
      mst = 0; mready = 0; macc = 0; mdone = 0; merr = 0; mreq = '0; mid = '0;
   endtask

   task automatic m_edge();
      int s = -1;
      int fs, cg;
      int out0 = m_out();
      int qn = fq.size();
      logic [63:0] w = {bus.req_rw, bus.req_addr, bus.req_wdata};
      bit do_push = bus.req_valid && mready;
      bit iss;
      for (int i = 7; i >= 0; i--) if (!mbusy[i]) s = i;
      iss = (qn > 0) && bus.if_ready && (s >= 0);
      if (bus.cpl_valid) begin
         fs = int'(bus.cpl_id) % 8;
         cg = int'(bus.cpl_id) / 8;
         if (mbusy[fs] && mgen[fs] == cg) begin
            mbusy[fs] = 0;
            mgen[fs]  = (mgen[fs] + 1) % 128;
         end else merr = 1;
      end
      macc = iss;
      if (iss) begin
         mreq = fq.pop_front();
         mid  = 10'(mgen[s] * 8 + s);
         mbusy[s] = 1;
      end
      if (do_push) fq.push_back(w);
      mdone = 0;
      case (mst)
         0: if (drain_req) mst = 1;
         1: if (qn == 0 && out0 == 0) begin mst = 2; mdone = 1; end
         default: if (!drain_req) mst = 0;
      endcase
      mready = (mst == 0) && (fq.size() < DEPTH);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("access_en",   64'(bus.access_en),          64'(macc));
      chk("request_out", bus.request_out,             mreq);
      chk("id",          64'(bus.identification_out), 64'(mid));
      chk("req_ready",   64'(bus.req_ready),          64'(mready));
      chk("outstanding", 64'(outstanding),            64'(m_out()));
      chk("err",         64'(err_spurious),           64'(merr));
      chk("drain_done",  64'(drain_done),             64'(mdone));
   endtask

   task automatic step();
      @(posedge clk);
      if (!reset) m_reset(); else m_edge();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      bus.req_valid = 0; bus.cpl_valid = 0; drain_req = 0;
      reset = 0;
      m_reset();
      #1;
      check_all();
      step();
      reset = 1;
      step();
   endtask

   task automatic push(input logic [63:0] w);
      bit ok = 0;
      {bus.req_rw, bus.req_addr, bus.req_wdata} = w;
      bus.req_valid = 1;
      for (int k = 0; k < 50 && !ok; k++) begin ok = mready; step(); end
      bus.req_valid = 0;
      chk("push_accept", 64'(ok), 64'd1);
   endtask

   task automatic cpl(input logic [9:0] id);
      bus.cpl_valid = 1; bus.cpl_id = id;
      step();
      bus.cpl_valid = 0;
   endtask

   task automatic cpl_any();
      int c[$];
      int s;
      for (int i = 0; i < 8; i++) if (mbusy[i]) c.push_back(i);
      if (c.size() > 0) begin
         s = c[$urandom_range(c.size() - 1)];
         cpl(10'(mgen[s] * 8 + s));
      end else step();
   endtask

   initial begin
      bus.req_valid = 0; bus.req_rw = 0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.if_ready = 0; bus.cpl_valid = 0; bus.cpl_id = '0;

      // First accept and issue after reset.
      do_reset();
      bus.if_ready = 1;
      push({1'b1, 31'h10, 32'hA5});
      chk("first_acc_early", 64'(bus.access_en), 64'd0);
      step();
      chk("first_acc",  64'(bus.access_en), 64'd1);
      chk("first_req",  bus.request_out, 64'h80000010_000000A5);
      chk("first_id",   64'(bus.identification_out), 64'h0);
      step();

      // Nine requests, eight slots; completion of ID 3 frees slot 3 for gen 1.
      do_reset();
      bus.if_ready = 1;
      for (int i = 0; i < 9; i++) push({1'b0, 31'(i * 4), 32'(i + 100)});
      repeat (3) step();
      chk("full_slots", 64'(outstanding), 64'd8);
      chk("ninth_held", 64'(bus.access_en), 64'd0);
      cpl(10'h003);
      step();
      chk("reissue_en", 64'(bus.access_en), 64'd1);
      chk("reissue_id", 64'(bus.identification_out), 64'h00B);

      // Spurious completions: wrong generation, then a free slot.
      do_reset();
      bus.if_ready = 1;
      for (int i = 0; i < 4; i++) push(64'($urandom));
      repeat (2) step();
      cpl(10'h00B);
      chk("spur_gen", 64'(err_spurious), 64'd1);
      chk("spur_out", 64'(outstanding), 64'd4);
      do_reset();
      cpl(10'h005);
      chk("spur_free", 64'(err_spurious), 64'd1);

      // Fill FIFO while downstream stalled, then release.
      do_reset();
      bus.if_ready = 0;
      for (int i = 0; i < 4; i++) push({1'b1, 31'(i), 32'(i)});
      chk("full_ready", 64'(bus.req_ready), 64'd0);
      repeat (2) step();
      chk("stall_acc", 64'(bus.access_en), 64'd0);
      bus.if_ready = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("b2b_acc", 64'(bus.access_en), 64'd1);
      end
      step();
      chk("b2b_end", 64'(bus.access_en), 64'd0);

      // Drain with queued and outstanding work.
      do_reset();
      bus.if_ready = 1;
      for (int i = 0; i < 3; i++) push(64'($urandom));
      step();
      bus.if_ready = 0;
      for (int i = 0; i < 2; i++) push(64'($urandom));
      drain_req = 1;
      step();
      chk("drain_ready", 64'(bus.req_ready), 64'd0);
      bus.if_ready = 1;
      repeat (2) step();
      chk("drain_out", 64'(outstanding), 64'd5);
      for (int i = 0; i < 5; i++) cpl_any();
      step();
      chk("drain_pulse", 64'(drain_done), 64'd1);
      step();
      chk("drain_once", 64'(drain_done), 64'd0);
      drain_req = 0;
      step();
      chk("back_run", 64'(bus.req_ready), 64'd1);

      // Reset with work in flight.
      do_reset();
      bus.if_ready = 1;
      for (int i = 0; i < 5; i++) push(64'($urandom));
      step();
      bus.if_ready = 0;
      for (int i = 0; i < 2; i++) push(64'($urandom));
      reset = 0;
      m_reset();
      #1;
      check_all();
      chk("rst_acc", 64'(bus.access_en), 64'd0);
      chk("rst_out", 64'(outstanding), 64'd0);
      step();
      reset = 1;
      step();
      bus.if_ready = 1;
      push(64'h1234);
      step();
      chk("rst_id_acc", 64'(bus.access_en), 64'd1);
      chk("rst_id", 64'(bus.identification_out), 64'h0);

      // Random traffic with legal completions and occasional drains.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int c[$];
         int s;
         bus.req_valid = 1'($urandom);
         bus.req_rw    = 1'($urandom);
         bus.req_addr  = 31'($urandom);
         bus.req_wdata = $urandom;
         bus.if_ready  = ($urandom % 4) != 0;
         bus.cpl_valid = 0;
         for (int i = 0; i < 8; i++) if (mbusy[i]) c.push_back(i);
         if (c.size() > 0 && ($urandom % 5) < 2) begin
            s = c[$urandom_range(c.size() - 1)];
            bus.cpl_valid = 1;
            bus.cpl_id    = 10'(mgen[s] * 8 + s);
         end
         if (($urandom % 64) == 0) drain_req = !drain_req;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
